// File: rtl/piece_spawner.sv
// Moves the 4-cell piece from the preview box onto the top of the playfield, checks the
// spawn cells for a collision, clears the preview and publishes the active cell addresses.
module piece_spawner #(
  parameter logic [7:0]  PreviewBase  = 8'd240,
  parameter int unsigned PreviewW     = 3,
  parameter int unsigned PreviewCells = 12,
  parameter int unsigned FieldW       = 10,
  parameter int unsigned SpawnCol     = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [7:0] rdata_i,
  output logic       we_o,
  output logic [7:0] addr_o,
  output logic [7:0] wdata_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       game_over_o,
  output logic       bad_piece_o,
  output logic [7:0] colour_o,
  output logic [7:0] act_1_addr_o,
  output logic [7:0] act_2_addr_o,
  output logic [7:0] act_3_addr_o,
  output logic [7:0] act_4_addr_o
);

  typedef enum logic [2:0] {StIdle, StScan, StCheck, StWrite, StClear, StDone} state_e;

  localparam logic [3:0] LastCell = 4'(PreviewCells - 1);
  localparam logic [1:0] LastCol  = 2'(PreviewW - 1);

  state_e          state_q, state_d;
  logic            en_q;
  logic            ph_q, ph_d;
  logic [3:0]      idx_q, idx_d;
  logic [1:0]      row_q, row_d;
  logic [1:0]      col_q, col_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            hit_q, hit_d;
  logic [7:0]      scol_q, scol_d;
  logic [3:0][7:0] tgt_q, tgt_d;
  logic [3:0][7:0] act_q, act_d;
  logic [7:0]      colour_q, colour_d;
  logic            we_q, we_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            go_q, go_d;
  logic            bad_q, bad_d;

  logic            cell_hit;
  logic            any_hit;
  logic [3:0]      cnt_inc;

  function automatic logic [7:0] target(input logic [1:0] row, input logic [1:0] col);
    int unsigned t;
    t = 32'(row) * FieldW + SpawnCol + 32'(col);
    return t[7:0];
  endfunction

  assign cell_hit = (rdata_i != 8'd0);
  assign cnt_inc  = cnt_q + {3'b000, cell_hit};
  // Once game over is latched every later spawn is refused at the collision check.
  assign any_hit  = hit_q | cell_hit | go_q;

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    idx_d    = idx_q;
    row_d    = row_q;
    col_d    = col_q;
    cnt_d    = cnt_q;
    hit_d    = hit_q;
    scol_d   = scol_q;
    tgt_d    = tgt_q;
    act_d    = act_q;
    colour_d = colour_q;
    go_d     = go_q;
    bad_d    = bad_q;
    we_d     = 1'b0;
    wdata_d  = 8'd0;
    addr_d   = addr_q;

    unique case (state_q)
      StIdle: begin
        addr_d = 8'd0;
        if (en_i && !en_q) begin
          state_d = StScan;
          addr_d  = PreviewBase;
          ph_d    = 1'b0;
          idx_d   = 4'd0;
          row_d   = 2'd0;
          col_d   = 2'd0;
          cnt_d   = 4'd0;
          hit_d   = 1'b0;
          scol_d  = 8'd0;
        end
      end
      StScan: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          if (cell_hit) begin
            if (cnt_q < 4'd4) tgt_d[cnt_q[1:0]] = target(row_q, col_q);
            if (cnt_q == 4'd0) scol_d = rdata_i;
          end
          cnt_d = cnt_inc;
          if (idx_q == LastCell) begin
            idx_d = 4'd0;
            if (cnt_inc == 4'd4) begin
              state_d = StCheck;
              addr_d  = tgt_d[0];
            end else begin
              state_d = StDone;
              bad_d   = 1'b1;
              addr_d  = 8'd0;
            end
          end else begin
            idx_d  = idx_q + 4'd1;
            addr_d = PreviewBase + 8'(idx_q) + 8'd1;
            if (col_q == LastCol) begin
              col_d = 2'd0;
              row_d = row_q + 2'd1;
            end else begin
              col_d = col_q + 2'd1;
            end
          end
        end
      end
      StCheck: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          hit_d = any_hit;
          if (idx_q == 4'd3) begin
            idx_d = 4'd0;
            if (any_hit) begin
              state_d = StDone;
              go_d    = 1'b1;
              addr_d  = 8'd0;
            end else begin
              state_d  = StWrite;
              we_d     = 1'b1;
              addr_d   = tgt_q[0];
              wdata_d  = scol_q;
              act_d    = tgt_q;
              colour_d = scol_q;
            end
          end else begin
            idx_d  = idx_q + 4'd1;
            addr_d = tgt_q[idx_q[1:0] + 2'd1];
          end
        end
      end
      StWrite: begin
        we_d = 1'b1;
        if (idx_q == 4'd3) begin
          state_d = StClear;
          idx_d   = 4'd0;
          addr_d  = PreviewBase;
        end else begin
          idx_d   = idx_q + 4'd1;
          addr_d  = tgt_q[idx_q[1:0] + 2'd1];
          wdata_d = scol_q;
        end
      end
      StClear: begin
        if (idx_q == LastCell) begin
          state_d = StDone;
          idx_d   = 4'd0;
          addr_d  = 8'd0;
        end else begin
          we_d   = 1'b1;
          idx_d  = idx_q + 4'd1;
          addr_d = PreviewBase + 8'(idx_q) + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        addr_d  = 8'd0;
      end
      default: begin
        state_d = StIdle;
        addr_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      en_q     <= 1'b0;
      ph_q     <= 1'b0;
      idx_q    <= 4'd0;
      row_q    <= 2'd0;
      col_q    <= 2'd0;
      cnt_q    <= 4'd0;
      hit_q    <= 1'b0;
      scol_q   <= 8'd0;
      tgt_q    <= '0;
      act_q    <= '0;
      colour_q <= 8'd0;
      we_q     <= 1'b0;
      addr_q   <= 8'd0;
      wdata_q  <= 8'd0;
      go_q     <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_i;
      ph_q     <= ph_d;
      idx_q    <= idx_d;
      row_q    <= row_d;
      col_q    <= col_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
      scol_q   <= scol_d;
      tgt_q    <= tgt_d;
      act_q    <= act_d;
      colour_q <= colour_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      go_q     <= go_d;
      bad_q    <= bad_d;
    end
  end

  assign we_o         = we_q;
  assign addr_o       = addr_q;
  assign wdata_o      = wdata_q;
  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StDone);
  assign game_over_o  = go_q;
  assign bad_piece_o  = bad_q;
  assign colour_o     = colour_q;
  assign act_1_addr_o = act_q[0];
  assign act_2_addr_o = act_q[1];
  assign act_3_addr_o = act_q[2];
  assign act_4_addr_o = act_q[3];

endmodule
